// File: rtl/ship_control_mapper.sv
// Maps held key levels onto ship thrust/rotate/shoot/start actions.
// Selects the control mode glitch-free and arbitrates opposing keys.
module ship_control_mapper #(
  parameter int FIRE_PERIOD = 25_000_000,
  parameter bit AUTOFIRE    = 1'b1,
  parameter bit LAST_WINS   = 1'b1,
  parameter int CNT_W       = $clog2(FIRE_PERIOD)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] key_in,
  input  logic [1:0] ctrl_mode,
  input  logic       enable,
  output logic       forward,
  output logic       backward,
  output logic       left_rotate,
  output logic       right_rotate,
  output logic       shoot,
  output logic       start,
  output logic [1:0] mode_active
);

  typedef enum logic [1:0] {
    IDLE,
    COOL,
    WAIT_REL
  } shoot_state_e;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FIRE_PERIOD - 1);

  logic [1:0] mode_req;
  logic       raw_f, raw_b, raw_l, raw_r;
  logic       prev_f, prev_b, prev_l, prev_r, prev_enter;
  logic       rise_f, rise_b, rise_l, rise_r;
  logic       pref_fb, pref_lr, pref_fb_n, pref_lr_n;
  logic       fwd_d, bwd_d, lft_d, rgt_d;
  logic       space;

  shoot_state_e     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             shoot_n;

  assign mode_req = (ctrl_mode == 2'd3) ? 2'd0 : ctrl_mode;
  assign space    = key_in[8];

  // Mode only switches with no direction key down, so nothing sticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_active <= mode_req;
    end else if (key_in[7:0] == 8'd0) begin
      mode_active <= mode_req;
    end
  end

  always_comb begin
    raw_f = key_in[6];
    raw_b = key_in[7];
    raw_l = key_in[4];
    raw_r = key_in[5];
    case (mode_active)
      2'd1: begin
        raw_f = key_in[0];
        raw_b = key_in[2];
        raw_l = key_in[1];
        raw_r = key_in[3];
      end
      2'd2: begin
        raw_f = key_in[6] | key_in[0];
        raw_b = key_in[7] | key_in[2];
        raw_l = key_in[4] | key_in[1];
        raw_r = key_in[5] | key_in[3];
      end
      default: ;
    endcase
  end

  assign rise_f = raw_f & ~prev_f;
  assign rise_b = raw_b & ~prev_b;
  assign rise_l = raw_l & ~prev_l;
  assign rise_r = raw_r & ~prev_r;

  // pref_fb=1: backward is newer; pref_lr=1: left is newer.
  always_comb begin
    pref_fb_n = pref_fb;
    pref_lr_n = pref_lr;
    if (rise_f) pref_fb_n = 1'b0;
    else if (rise_b) pref_fb_n = 1'b1;
    if (rise_r) pref_lr_n = 1'b0;
    else if (rise_l) pref_lr_n = 1'b1;
  end

  assign fwd_d = raw_f & (~raw_b | (LAST_WINS & ~pref_fb_n));
  assign bwd_d = raw_b & (~raw_f | (LAST_WINS & pref_fb_n));
  assign rgt_d = raw_r & (~raw_l | (LAST_WINS & ~pref_lr_n));
  assign lft_d = raw_l & (~raw_r | (LAST_WINS & pref_lr_n));

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_f       <= 1'b0;
      prev_b       <= 1'b0;
      prev_l       <= 1'b0;
      prev_r       <= 1'b0;
      prev_enter   <= 1'b0;
      pref_fb      <= 1'b0;
      pref_lr      <= 1'b0;
      forward      <= 1'b0;
      backward     <= 1'b0;
      left_rotate  <= 1'b0;
      right_rotate <= 1'b0;
      start        <= 1'b0;
    end else begin
      prev_f       <= raw_f;
      prev_b       <= raw_b;
      prev_l       <= raw_l;
      prev_r       <= raw_r;
      prev_enter   <= key_in[9];
      pref_fb      <= enable & pref_fb_n;
      pref_lr      <= enable & pref_lr_n;
      forward      <= enable & fwd_d;
      backward     <= enable & bwd_d;
      left_rotate  <= enable & lft_d;
      right_rotate <= enable & rgt_d;
      start        <= enable & key_in[9] & ~prev_enter;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shoot_n = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (space) begin
            shoot_n = 1'b1;
            cnt_n   = RELOAD;
            state_n = COOL;
          end
        end
        COOL: begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else if (space) begin
            if (AUTOFIRE) begin
              shoot_n = 1'b1;
              cnt_n   = RELOAD;
            end else begin
              state_n = WAIT_REL;
            end
          end else begin
            state_n = IDLE;
          end
        end
        WAIT_REL: begin
          if (!space) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      shoot <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shoot <= shoot_n;
    end
  end

endmodule
